// File: rtl/mult_pkg.sv
// Shared definitions for the multiply-accumulate path: FSM state encoding
// and the default widths used by both the multiplier stage and mult_acc.
package mult_pkg;

  localparam int PROD_W    = 64;
  localparam int DEF_ACC_W = 64;
  localparam int DEF_LEN_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/mult_acc.sv
// Batch accumulator behind the 64-bit multiplier: sums len products and
// presents the sum plus a sticky overflow flag through a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for the first product of a batch; acc_out reads 0
// ACCUM | summing products until eff_len words have been accepted
// DONE  | result held on acc_out/ovf until out_ready
module mult_acc
  import mult_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic [PROD_W-1:0] prod,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LEN_W-1:0]  len,
  output logic [ACC_W-1:0]  acc_out,
  output logic              ovf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovf_q, ovf_d;

  logic               in_hs;
  logic [LEN_W-1:0]   eff_len_in;
  logic [LEN_W-1:0]   cnt_inc;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W:0]     sum;

  // A zero-length request is treated as a single-word batch.
  assign eff_len_in = (len == '0) ? LEN_W'(1) : len;
  assign cnt_inc    = cnt_q + LEN_W'(1);
  assign prod_ext   = ACC_W'(prod);
  assign sum        = {1'b0, acc_q} + {1'b0, prod_ext};
  assign in_hs      = in_valid && in_ready;

  always_ff @(posedge CLK) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_hs) state_d = (eff_len_in == LEN_W'(1)) ? DONE : ACCUM;
      ACCUM:   if (in_hs && (cnt_inc == len_q)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = !rst && (state_q != DONE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    len_d = len_q;
    case (state_q)
      IDLE: begin
        if (in_hs) begin
          acc_d = prod_ext;
          cnt_d = LEN_W'(1);
          ovf_d = 1'b0;
          len_d = eff_len_in;
        end
      end
      ACCUM: begin
        if (in_hs) begin
          acc_d = sum[ACC_W-1:0];
          cnt_d = cnt_inc;
          ovf_d = ovf_q | sum[ACC_W];
        end
      end
      DONE: begin
        // Clearing on consume keeps acc_out at 0 while idle.
        if (out_ready) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end
      end
      default: begin
        acc_d = '0;
        cnt_d = '0;
        ovf_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      len_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      len_q <= len_d;
    end
  end

  assign acc_out = acc_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_mult_acc.sv
// Self-checking bench for mult_acc: directed batches plus random batches
// compared against a wide-arithmetic reference sum.
module tb_mult_acc;

  logic        CLK;
  logic        rst;
  logic [63:0] prod;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  len;
  logic [63:0] acc_out;
  logic        ovf;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [63:0] pv [0:15];

  mult_acc #(.ACC_W(64), .LEN_W(8)) dut (
    .CLK       (CLK),
    .rst       (rst),
    .prod      (prod),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .len       (len),
    .acc_out   (acc_out),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Sends pv[0..n-1] as one batch (n is the effective length), then holds the
  // result for 'hold' cycles with in_valid still asserted before consuming it.
  task automatic do_batch(input string tag, input int lenv, input bit gaps, input int hold);
    int n;
    logic [127:0] total;
    logic [63:0]  exp_acc;
    logic         exp_ovf;
    n = (lenv == 0) ? 1 : lenv;
    total = '0;
    for (int i = 0; i < n; i++) total = total + {64'd0, pv[i]};
    exp_acc = total[63:0];
    exp_ovf = |total[127:64];

    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0 && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        prod     = rnd64();
        tick();
        chk({tag, ".gap_busy"}, {63'd0, busy}, 64'd1);
        chk({tag, ".gap_outv"}, {63'd0, out_valid}, 64'd0);
      end
      in_valid = 1'b1;
      prod     = pv[i];
      len      = (i == 0) ? 8'(lenv) : 8'($urandom_range(0, 255));
      tick();
      if (i < n - 1) begin
        chk({tag, ".acc_outv"}, {63'd0, out_valid}, 64'd0);
        chk({tag, ".acc_rdy"},  {63'd0, in_ready},  64'd1);
      end
    end

    chk({tag, ".outv"}, {63'd0, out_valid}, 64'd1);
    chk({tag, ".acc"},  acc_out, exp_acc);
    chk({tag, ".ovf"},  {63'd0, ovf}, {63'd0, exp_ovf});
    chk({tag, ".busy"}, {63'd0, busy}, 64'd1);

    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      prod      = rnd64();
      tick();
      chk({tag, ".hold_rdy"},  {63'd0, in_ready},  64'd0);
      chk({tag, ".hold_outv"}, {63'd0, out_valid}, 64'd1);
      chk({tag, ".hold_acc"},  acc_out, exp_acc);
      chk({tag, ".hold_ovf"},  {63'd0, ovf}, {63'd0, exp_ovf});
    end

    // Release cycle: the word still on prod must not be taken while in DONE.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    prod      = rnd64();
    tick();
    out_ready = 1'b0;
    chk({tag, ".rel_outv"}, {63'd0, out_valid}, 64'd0);
    chk({tag, ".rel_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, ".rel_acc"},  acc_out, 64'd0);
    chk({tag, ".rel_rdy"},  {63'd0, in_ready}, 64'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    prod      = '0;
    in_valid  = 1'b0;
    len       = '0;
    out_ready = 1'b0;

    // Reset held for 4 cycles
    repeat (4) tick();
    chk("rst.outv", {63'd0, out_valid}, 64'd0);
    chk("rst.busy", {63'd0, busy}, 64'd0);
    chk("rst.acc",  acc_out, 64'd0);
    chk("rst.rdy",  {63'd0, in_ready}, 64'd0);
    rst = 1'b0;
    #1;
    chk("rst.rdy_after", {63'd0, in_ready}, 64'd1);
    tick();

    // Basic batch, back-to-back words
    pv[0] = 64'd10; pv[1] = 64'd20; pv[2] = 64'd30;
    do_batch("basic", 3, 1'b0, 0);

    // len=0 and len=1 both mean a single word
    pv[0] = 64'h1234;
    do_batch("len0", 0, 1'b0, 0);
    do_batch("len1", 1, 1'b0, 0);

    // Carry out of bit 63
    pv[0] = 64'hFFFF_FFFF_FFFF_FFFF; pv[1] = 64'd2;
    do_batch("ovf", 2, 1'b0, 0);

    // Backpressure for 5 cycles, then an immediate follow-on batch
    pv[0] = 64'd5; pv[1] = 64'd6;
    do_batch("bp", 2, 1'b0, 5);
    pv[0] = 64'd100;
    do_batch("bp_next", 1, 1'b0, 0);

    // Reset after 2 of 4 words discards the partial batch
    in_valid = 1'b1;
    len      = 8'd4;
    prod     = 64'd11;
    tick();
    prod     = 64'd22;
    tick();
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    chk("midrst.outv", {63'd0, out_valid}, 64'd0);
    chk("midrst.busy", {63'd0, busy}, 64'd0);
    chk("midrst.acc",  acc_out, 64'd0);
    chk("midrst.rdy",  {63'd0, in_ready}, 64'd0);
    rst = 1'b0;
    #1;
    chk("midrst.rdy_after", {63'd0, in_ready}, 64'd1);
    tick();
    chk("midrst.idle_outv", {63'd0, out_valid}, 64'd0);
    pv[0] = 64'd7;
    do_batch("midrst_next", 1, 1'b0, 0);

    // Random batches with idle gaps, held results and occasional overflow
    for (int b = 0; b < 25; b++) begin
      int lv;
      lv = $urandom_range(0, 8);
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(0, 3) == 0) pv[i] = 64'hFFFF_FFFF_0000_0000 | 64'($urandom());
        else                           pv[i] = rnd64() >> $urandom_range(0, 40);
      end
      do_batch("rand", lv, 1'b1, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
